// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU opcodes, the hard-wired zero
// register and the operand forwarding-select encodings.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_OP_AND  = 4'd0;
  localparam logic [3:0] ALU_OP_OR   = 4'd1;
  localparam logic [3:0] ALU_OP_ADD  = 4'd2;
  localparam logic [3:0] ALU_OP_SLL  = 4'd3;
  localparam logic [3:0] ALU_OP_SRL  = 4'd4;
  localparam logic [3:0] ALU_OP_SRA  = 4'd5;
  localparam logic [3:0] ALU_OP_SUB  = 4'd6;
  localparam logic [3:0] ALU_OP_SLT  = 4'd7;
  localparam logic [3:0] ALU_OP_XOR  = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU = 4'd9;
  localparam logic [3:0] ALU_OP_LUI  = 4'd10;
  localparam logic [3:0] ALU_OP_NOR  = 4'd12;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source operand forwarding: picks the youngest in-flight producer of a
// register, falling back to the value latched at ID/EX capture.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] data
);

  logic [1:0] sel;

  // r0 is never forwarded; EX/MEM is younger so it wins over MEM/WB
  always_comb begin
    sel = FWD_REG;
    if ((addr != REG_ZERO) && exmem_reg_write && (exmem_rd == addr))
      sel = FWD_EXMEM;
    else if ((addr != REG_ZERO) && memwb_reg_write && (memwb_rd == addr))
      sel = FWD_MEMWB;
  end

  always_comb begin
    data = reg_val;
    case (sel)
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_result;
      default:   data = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand assembly, forwarding and
// load-use hazard detection for the 5-stage MIPS pipeline.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_src1_sa,
  input  logic [4:0]        id_sa,
  input  logic              id_src2_imm,
  input  logic [15:0]       id_imm16,
  input  logic              id_ext_signed,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exmem_reg_write,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  input  logic              stall_in,
  input  logic              flush,
  output logic              ex_valid,
  output logic [3:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_opnd1,
  output logic [DATA_W-1:0] ex_opnd2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_stall
);

  logic              valid_q;
  logic [3:0]        aluop_q;
  logic [REG_AW-1:0] rs_addr_q, rt_addr_q, rd_q;
  logic [DATA_W-1:0] rs_val_q, rt_val_q, imm32_q;
  logic              src1_sa_q, src2_imm_q;
  logic [4:0]        sa_q;
  logic              reg_write_q, mem_read_q, mem_write_q;
  logic [DATA_W-1:0] fwd_rs, fwd_rt, id_imm32;

  assign id_imm32 = id_ext_signed ? {{(DATA_W-16){id_imm16[15]}}, id_imm16}
                                  : {{(DATA_W-16){1'b0}}, id_imm16};

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .addr(rs_addr_q), .reg_val(rs_val_q),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data(fwd_rs)
  );

  id_ex_stage_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .addr(rt_addr_q), .reg_val(rt_val_q),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .data(fwd_rt)
  );

  // While held, absorb forwarded values so a producer retiring past WB is not lost
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      aluop_q     <= ALU_OP_ADD;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm32_q     <= '0;
      src1_sa_q   <= 1'b0;
      src2_imm_q  <= 1'b0;
      sa_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush || (load_use_stall && !stall_in)) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (stall_in) begin
      if (valid_q) begin
        rs_val_q <= fwd_rs;
        rt_val_q <= fwd_rt;
      end
    end else begin
      valid_q     <= id_valid;
      aluop_q     <= id_aluop;
      rs_addr_q   <= id_rs_addr;
      rt_addr_q   <= id_rt_addr;
      rd_q        <= id_rd_addr;
      rs_val_q    <= id_rs_data;
      rt_val_q    <= id_rt_data;
      imm32_q     <= id_imm32;
      src1_sa_q   <= id_src1_sa;
      src2_imm_q  <= id_src2_imm;
      sa_q        <= id_sa;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_aluop      = aluop_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = valid_q & reg_write_q;
  assign ex_mem_read   = valid_q & mem_read_q;
  assign ex_mem_write  = valid_q & mem_write_q;
  assign ex_opnd1      = src1_sa_q ? {{(DATA_W-5){1'b0}}, sa_q} : fwd_rs;
  assign ex_opnd2      = src2_imm_q ? imm32_q : fwd_rt;
  assign ex_store_data = fwd_rt;

  assign load_use_stall = !flush && !stall_in && ex_mem_read && id_valid &&
                          (rd_q != REG_ZERO) &&
                          ((id_rs_used && (id_rs_addr == rd_q)) ||
                           (id_rt_used && (id_rt_addr == rd_q)));

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-side operand assembly for the 5-stage MIPS pipeline.
- Captures decoded fields from ID and extends the immediate.
- Applies EX/MEM and MEM/WB forwarding, then drives the 4-bit ALU opcode and two 32-bit operands straight into the ALU.
- Detects load-use hazards and inserts bubbles; honours downstream stall and branch flush.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width; register 0 is hard-wired zero and never forwarded

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_aluop  in  4  ALU opcode (`ALU_OP_*)
- id_rs_addr, id_rt_addr  in  5  source register numbers
- id_rs_data, id_rt_data  in  32  register-file read data (regfile is write-first)
- id_rs_used, id_rt_used  in  1  instruction actually reads rs/rt
- id_src1_sa  in  1  opnd1 = zero-extended shamt instead of rs
- id_sa  in  5  shift amount field
- id_src2_imm  in  1  opnd2 = extended immediate instead of rt
- id_imm16  in  16  immediate field
- id_ext_signed  in  1  1 = sign-extend, 0 = zero-extend imm16
- id_rd_addr  in  5  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- exmem_reg_write, memwb_reg_write  in  1  forwarding source write enables
- exmem_rd, memwb_rd  in  5  forwarding destinations
- exmem_result, memwb_result  in  32  forwarding data
- stall_in  in  1  downstream (MEM) stall: hold EX
- flush  in  1  branch redirect: kill EX contents
- ex_valid  out  1  EX holds a real instruction
- ex_aluop  out  4  to ALU
- ex_opnd1, ex_opnd2  out  32  to ALU
- ex_store_data  out  32  forwarded rt for stores
- ex_rd_addr  out  5  destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control, gated by ex_valid
- load_use_stall  out  1  to hazard unit: freeze PC and IF/ID

Behaviour:
- Reset: all stage registers clear.
  - ex_valid=0, ex_aluop=`ALU_OP_ADD, data/address registers 0, control 0.
  - load_use_stall=0.
- Update priority at posedge clk: rst > flush > stall_in > load_use_stall > capture.
  - flush: ex_valid=0 and control bits cleared next cycle, regardless of stall_in.
  - stall_in: hold all fields, with the forward-capture rule below.
  - load_use_stall: load bubble (valid=0, controls 0); ID is held by the hazard unit.
  - capture: latch all id_* fields; ex_valid=id_valid.
- Immediate extension happens at capture: imm32 = ext_signed ? {{16{imm[15]}},imm} : {16'b0,imm}.
- Forwarding (combinational, 0 added latency), per source (rs, rt) with stored address a:
  - a != 0 and exmem_reg_write and exmem_rd == a -> exmem_result;
  - else a != 0 and memwb_reg_write and memwb_rd == a -> memwb_result;
  - else the stored register value.
  - EX/MEM has priority over MEM/WB.
- Forward-capture on hold: every stall_in cycle with ex_valid=1, the stored rs/rt values are overwritten with their forwarded values. A value cannot be lost when its producer leaves MEM/WB.
- Operand muxing:
  - ex_opnd1 = src1_sa ? {27'b0,sa} : fwd_rs.
  - ex_opnd2 = src2_imm ? imm32 : fwd_rt.
  - ex_store_data = fwd_rt.
- load_use_stall (combinational) = ex_valid & ex_mem_read & id_valid & (ex_rd_addr != 0) & ((id_rs_used & id_rs_addr == ex_rd_addr) | (id_rt_used & id_rt_addr == ex_rd_addr)).
  - Forced 0 when flush or stall_in is asserted.
  - Asserts for exactly one cycle per load-use pair.
- Bubbles: ex_reg_write/mem_read/mem_write are 0 whenever ex_valid=0. Forwarding logic ignores bubble outputs.
- Reset asserted mid-stall or mid-bubble: the next cycle is the reset state; no held data survives.

Decomposition:
- ALU opcode constants stay in the shared const.vh.
- Add to const.vh: REG_ZERO (5'd0) and forwarding-select encodings FWD_REG/FWD_EXMEM/FWD_MEMWB (2 bits).
- One sub-module, fwd_mux: address compare plus 3:1 select. Instantiate twice (rs, rt).

Test Plan:
- Reset then ADD r3=r1+r2 (r1=5, r2=7): cycle after capture -> ex_aluop=ADD, opnd1=5, opnd2=7, ex_valid=1.
- Back-to-back r1=... then use r1: exmem_rd=1, exmem_result=0x10 and memwb_rd=1, memwb_result=0x20 -> opnd1=0x10. With exmem_rd=0 and memwb_rd=0 (r0 write) -> stored value.
- LW r4 in EX, ID reads r4 as rt -> load_use_stall=1 for one cycle, next EX ex_valid=0 with controls 0. With ID reading r0 instead -> no stall.
- stall_in held 3 cycles while memwb forwards 0xDEAD to rs, then memwb_rd changes -> opnd1 stays 0xDEAD throughout.
- SLL sa=4, src1_sa=1 -> opnd1=0x4. ADDI with imm16=0xFFFF: signed -> opnd2=0xFFFFFFFF; ORI unsigned -> opnd2=0x0000FFFF.
- flush and stall_in together, then rst asserted during a load-use bubble -> ex_valid=0 next cycle; after rst all outputs at reset values.
